chunked_seq_adder: RTL and testbench

- Multi-cycle adder/subtractor: the parametrised successor to the lab's 4-bit ripple-carry adder.
- Adds or subtracts two WIDTH-bit operands in WIDTH/CHUNK cycles, one CHUNK-bit ripple slice per clock, with the carry held in a register between slices.
- Uses a start/busy/done handshake; reports carry-out and signed overflow.
- Sits between the switch/operand registers and the LEDR/HEX display logic.
- Trades latency for a short combinational carry path at any width.

---
 rtl/chunked_seq_adder.sv | 100 ++++++++++
 tb/tb_chunked_seq_adder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/chunked_seq_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit ripple slice per clock, carry held
// in a register between slices, start/busy/done handshake.
module chunked_seq_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             cin,
   output logic [WIDTH-1:0] S,
   output logic             cout,
   output logic             overflow,
   output logic             busy,
   output logic             done
);

   localparam int NCH = WIDTH / CHUNK;
   localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] op_a, op_b, res, res_next;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic [CHUNK-1:0] a_sl, b_sl;
   logic [CHUNK:0]   slice_sum;
   logic             msb_cin;
   logic             last;
   logic             accept;

   assign last   = (cnt == CW'(NCH - 1));
   assign accept = start && (state != RUN);
   assign busy   = (state == RUN);
   assign done   = (state == DONE);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values and simulation matches the synthesized flops.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // NOTE: every always_comb output gets a default first, so no path can leave
   // a signal unassigned and infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (last)  state_next = DONE;
         DONE:    state_next = start ? RUN : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // One slice of the ripple chain; this is the only carry path between registers.
   always_comb begin
      a_sl      = op_a[cnt*CHUNK +: CHUNK];
      b_sl      = op_b[cnt*CHUNK +: CHUNK];
      slice_sum = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry};
      // Sum bit = a ^ b ^ carry_in, so the carry into the slice MSB falls out directly.
      msb_cin   = a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ slice_sum[CHUNK-1];
      res_next  = res;
      res_next[cnt*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op_a     <= '0;
         op_b     <= '0;
         res      <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         S        <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else if (accept) begin
         // Subtraction is A + ~B + 1.
         op_a  <= A;
         op_b  <= sub ? ~B : B;
         carry <= sub ? 1'b1 : cin;
         cnt   <= '0;
         res   <= '0;
      end else if (state == RUN) begin
         res   <= res_next;
         carry <= slice_sum[CHUNK];
         cnt   <= cnt + 1'b1;
         if (last) begin
            S        <= res_next;
            cout     <= slice_sum[CHUNK];
            overflow <= msb_cin ^ slice_sum[CHUNK];
         end
      end
   end

endmodule

// File: tb/tb_chunked_seq_adder.sv
// Directed bench for chunked_seq_adder: a 16/4 instance for arithmetic and
// handshake cases, an 8/8 instance for the single-slice case.
module tb_chunked_seq_adder;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, sub, cin;
   logic [15:0] A, B, s;
   logic        cout, ovf, busy, done;

   logic        start8, sub8, cin8;
   logic [7:0]  a8, b8, s8;
   logic        cout8, ovf8, busy8, done8;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   chunked_seq_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
      .clk(clk), .reset(reset), .start(start), .sub(sub), .A(A), .B(B), .cin(cin),
      .S(s), .cout(cout), .overflow(ovf), .busy(busy), .done(done)
   );

   chunked_seq_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
      .clk(clk), .reset(reset), .start(start8), .sub(sub8), .A(a8), .B(b8), .cin(cin8),
      .S(s8), .cout(cout8), .overflow(ovf8), .busy(busy8), .done(done8)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called #1 after an edge; edge numbering counts the start edge as edge 1.
   task automatic wait_done16(input int first, output int edges, output int busy_cycles);
      edges       = first;
      busy_cycles = 0;
      while (!done && edges < 20) begin
         if (busy) busy_cycles++;
         @(posedge clk); #1;
         edges++;
      end
      check("done_seen", done, 1);
   endtask

   task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic sb,
                       input logic [15:0] es, input logic ec, input logic ev);
      int edges, bc;
      A = a; B = b; cin = ci; sub = sb; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check({tag, "_busy_after_start"}, busy, 1);
      wait_done16(1, edges, bc);
      check({tag, "_S"}, s, es);
      check({tag, "_cout"}, cout, ec);
      check({tag, "_ovf"}, ovf, ev);
      check({tag, "_done_edge"}, edges, 5);
      check({tag, "_busy_cycles"}, bc, 4);
      check({tag, "_busy_with_done"}, busy, 0);
      @(posedge clk); #1;
      check({tag, "_done_pulse_len"}, done, 0);
   endtask

   task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic sb, input logic [7:0] es, input logic ec, input logic ev);
      int edges;
      a8 = a; b8 = b; cin8 = 1'b0; sub8 = sb; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      edges  = 1;
      while (!done8 && edges < 10) begin
         @(posedge clk); #1;
         edges++;
      end
      check({tag, "_done_edge"}, edges, 2);
      check({tag, "_S"}, s8, es);
      check({tag, "_cout"}, cout8, ec);
      check({tag, "_ovf"}, ovf8, ev);
      @(posedge clk); #1;
   endtask

   initial begin
      int  e, bc;
      logic seen_done;

      reset = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; A = '0; B = '0;
      start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_S", s, 0);
      check("rst_cout", cout, 0);
      check("rst_ovf", ovf, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_busy8", busy8, 0);
      reset = 1'b0;
      @(posedge clk); #1;

      op16("add_00ff", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
      op16("add_ffff", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      op16("add_cin",  16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
      op16("sub_5_7",  16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      op16("sub_eq",   16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
      op16("add_mix",  16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0);

      // start with new operands mid-RUN must be ignored
      A = 16'h1234; B = 16'h1111; cin = 1'b0; sub = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      A = 16'hFFFF; B = 16'hFFFF; sub = 1'b1; cin = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done16(3, e, bc);
      check("midrun_S", s, 16'h2345);
      check("midrun_cout", cout, 0);
      check("midrun_ovf", ovf, 0);
      check("midrun_done_edge", e, 5);
      @(posedge clk); #1;
      check("midrun_idle_busy", busy, 0);

      // start held high through DONE: second operation starts on the done edge+1
      A = 16'h0001; B = 16'h0002; cin = 1'b0; sub = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      A = 16'h0010; B = 16'h0020;
      wait_done16(1, e, bc);
      check("b2b_first_S", s, 16'h0003);
      check("b2b_first_done_edge", e, 5);
      @(posedge clk); #1;
      start = 1'b0;
      check("b2b_second_busy", busy, 1);
      check("b2b_second_done_low", done, 0);
      wait_done16(1, e, bc);
      check("b2b_second_S", s, 16'h0030);
      check("b2b_second_done_edge", e, 5);
      @(posedge clk); #1;

      op16("sub_8000", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

      op8("w8_add", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
      op8("w8_sub", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
      op8("w8_ovf", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);

      // reset during the second RUN cycle aborts the operation
      A = 16'h1234; B = 16'h1111; cin = 1'b0; sub = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("abort_S", s, 0);
      check("abort_cout", cout, 0);
      check("abort_ovf", ovf, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_S8", s8, 0);
      seen_done = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         if (done) seen_done = 1'b1;
      end
      check("abort_no_done", seen_done, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
